// File: rtl/wb_pkg.sv
// Shared widths, grant encoding and the long-latency FIFO entry layout for the
// write-back arbiter.
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_PIPE,
    GRANT_LL
  } grant_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } ll_entry_t;

  // One-hot register mask; x0 has no storage, so it never maps to a busy bit.
  function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] mask;
    mask = '0;
    if (rd != '0) mask[rd] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO holding long-latency results until they win the write port.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wb_result_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  ll_entry_t push_entry,
  input  logic      pop,
  output ll_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  ll_entry_t     mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: non-blocking assignments for all clocked state so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // slots are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges in-order pipeline results and buffered long-latency results onto the
// single register-file write port, with starvation guard and busy scoreboard.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int LL_DEPTH   = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_valid,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_data,
  output logic                  pipe_ready,
  input  logic                  ll_valid,
  input  logic [REG_ADDR_W-1:0] ll_rd,
  input  logic [XLEN-1:0]       ll_data,
  output logic                  ll_ready,
  input  logic                  ll_issue_valid,
  input  logic [REG_ADDR_W-1:0] ll_issue_rd,
  output logic [NUM_REGS-1:0]   rd_busy,
  output logic                  rf_wr_en,
  output logic [REG_ADDR_W-1:0] rf_wr_addr,
  output logic [XLEN-1:0]       rf_wr_data
);

  localparam int               SW          = (STARVE_MAX > 2) ? $clog2(STARVE_MAX) : 1;
  localparam logic [SW-1:0]    STARVE_LAST = SW'(STARVE_MAX - 1);

  ll_entry_t     ll_head;
  ll_entry_t     ll_in;
  logic          fifo_full;
  logic          fifo_empty;
  logic          ll_push;
  logic          ll_pop;
  logic          starve_hit;
  logic          ll_urgent;
  logic [SW-1:0] starve_cnt;
  grant_t        grant;

  assign ll_in   = '{rd: ll_rd, data: ll_data};
  assign ll_ready = !fifo_full;
  assign ll_push  = ll_valid && !fifo_full;

  wb_result_fifo #(
    .DEPTH (LL_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (ll_push),
    .push_entry (ll_in),
    .pop        (ll_pop),
    .head       (ll_head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // The head must go now: it has waited too long, or the FIFO can take no more.
  assign starve_hit = (starve_cnt == STARVE_LAST);
  assign ll_urgent  = !fifo_empty && (starve_hit || fifo_full);
  assign pipe_ready = !ll_urgent;

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    grant = GRANT_NONE;
    if (!fifo_empty && (!pipe_valid || ll_urgent)) grant = GRANT_LL;
    else if (pipe_valid)                           grant = GRANT_PIPE;
  end

  assign ll_pop = (grant == GRANT_LL);

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (fifo_empty || ll_pop) begin
      starve_cnt <= '0;
    end else if (!starve_hit) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Clear-then-set ordering makes a same-cycle reissue keep the register busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_busy <= '0;
    end else begin
      rd_busy <= (rd_busy & ~(ll_pop ? reg_mask(ll_head.rd) : '0))
               | (ll_issue_valid ? reg_mask(ll_issue_rd) : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else begin
      unique case (grant)
        GRANT_PIPE: begin
          rf_wr_en   <= pipe_we && (pipe_rd != '0);
          rf_wr_addr <= pipe_rd;
          rf_wr_data <= pipe_data;
        end
        GRANT_LL: begin
          rf_wr_en   <= (ll_head.rd != '0);
          rf_wr_addr <= ll_head.rd;
          rf_wr_data <= ll_head.data;
        end
        default: rf_wr_en <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench: expected register-file writes are queued up front and a
// negedge monitor matches every rf_wr_en pulse against the queue head.
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_ready;
  logic        ll_valid;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        ll_ready;
  logic        ll_issue_valid;
  logic [4:0]  ll_issue_rd;
  logic [31:0] rd_busy;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;

  int checks   = 0;
  int failures = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  wb_write_arbiter #(
    .LL_DEPTH   (4),
    .STARVE_MAX (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pipe_valid     (pipe_valid),
    .pipe_we        (pipe_we),
    .pipe_rd        (pipe_rd),
    .pipe_data      (pipe_data),
    .pipe_ready     (pipe_ready),
    .ll_valid       (ll_valid),
    .ll_rd          (ll_rd),
    .ll_data        (ll_data),
    .ll_ready       (ll_ready),
    .ll_issue_valid (ll_issue_valid),
    .ll_issue_rd    (ll_issue_rd),
    .rd_busy        (rd_busy),
    .rf_wr_en       (rf_wr_en),
    .rf_wr_addr     (rf_wr_addr),
    .rf_wr_data     (rf_wr_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_valid     = 1'b0;
    pipe_we        = 1'b0;
    pipe_rd        = '0;
    pipe_data      = '0;
    ll_valid       = 1'b0;
    ll_rd          = '0;
    ll_data        = '0;
    ll_issue_valid = 1'b0;
    ll_issue_rd    = '0;
  endtask

  task automatic idle_cycles(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) tick();
  endtask

  // Scoreboard monitor: every write the DUT presents must match the queue head.
  always @(negedge clk) begin
    if (rf_wr_en === 1'b1) begin
      logic [36:0] e;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: addr=%0d data=0x%08h with nothing expected",
                 rf_wr_addr, rf_wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(rf_wr_addr), 32'(e[36:32]));
        check("wr_data", rf_wr_data, e[31:0]);
      end
    end
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_wr_en", 32'(rf_wr_en), 32'd0);
    check("rst_wr_addr", 32'(rf_wr_addr), 32'd0);
    check("rst_wr_data", rf_wr_data, 32'd0);
    check("rst_busy", rd_busy, 32'd0);
    check("rst_ll_ready", 32'(ll_ready), 32'd1);
    check("rst_pipe_ready", 32'(pipe_ready), 32'd1);
    tick();

    // 1: pipe only
    expect_wr(5'd5, 32'hDEADBEEF);
    pipe_valid = 1'b1; pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
    @(negedge clk);
    check("t1_pipe_ready", 32'(pipe_ready), 32'd1);
    tick();
    idle_inputs();
    @(negedge clk);
    check("t1_wr_en", 32'(rf_wr_en), 32'd1);
    tick();
    idle_cycles(2);

    // 2: LL result in an idle slot, busy bit cleared by its pop
    expect_wr(5'd7, 32'h12345678);
    ll_issue_valid = 1'b1; ll_issue_rd = 5'd7;
    tick();
    idle_inputs();
    ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h12345678;
    @(negedge clk);
    check("t2_busy_set", rd_busy, 32'h0000_0080);
    tick();
    idle_inputs();
    @(negedge clk);
    check("t2_rf_idle_before_pop", 32'(rf_wr_en), 32'd0);
    tick();
    @(negedge clk);
    check("t2_busy_clear", rd_busy, 32'd0);
    check("t2_wr_en", 32'(rf_wr_en), 32'd1);
    tick();
    idle_cycles(2);

    // 3: starvation guard, one LL entry against a continuous pipe
    for (int i = 0; i < 8; i++) expect_wr(5'd10, 32'h100 + 32'(i));
    expect_wr(5'd3, 32'hAAAA0003);
    expect_wr(5'd10, 32'h108);
    begin
      int k = 0;
      for (int c = 0; c < 10; c++) begin
        pipe_valid = 1'b1; pipe_we = 1'b1; pipe_rd = 5'd10; pipe_data = 32'h100 + 32'(k);
        ll_valid = (c == 0); ll_rd = 5'd3; ll_data = 32'hAAAA0003;
        @(negedge clk);
        check($sformatf("t3_pipe_ready_c%0d", c), 32'(pipe_ready), (c == 8) ? 32'd0 : 32'd1);
        if (c != 8) k++;
        tick();
      end
    end
    idle_cycles(3);

    // 4: FIFO fills, pipe is held off, push while full is rejected
    for (int i = 0; i < 4; i++) expect_wr(5'd10, 32'h200 + 32'(i));
    expect_wr(5'd11, 32'hBB00_0011);
    expect_wr(5'd10, 32'h204);
    expect_wr(5'd12, 32'hBB00_0012);
    expect_wr(5'd13, 32'hBB00_0013);
    expect_wr(5'd14, 32'hBB00_0014);
    for (int c = 0; c < 6; c++) begin
      pipe_valid = 1'b1; pipe_we = 1'b1; pipe_rd = 5'd10;
      pipe_data = 32'h200 + 32'((c < 4) ? c : 4);
      ll_valid = (c < 5); ll_rd = 5'(11 + c); ll_data = 32'hBB00_0011 + 32'(c);
      @(negedge clk);
      if (c == 3) check("t4_ll_ready_before_full", 32'(ll_ready), 32'd1);
      if (c == 4) begin
        check("t4_ll_ready_full", 32'(ll_ready), 32'd0);
        check("t4_pipe_ready_full", 32'(pipe_ready), 32'd0);
      end
      if (c == 5) check("t4_pipe_ready_after_pop", 32'(pipe_ready), 32'd1);
      tick();
    end
    idle_cycles(5);
    check("t4_drained_ll_ready", 32'(ll_ready), 32'd1);

    // 5: x0 and no-write results are consumed silently; set beats clear
    pipe_valid = 1'b1; pipe_we = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h55;
    tick();
    pipe_rd = 5'd6; pipe_we = 1'b0; pipe_data = 32'h66;
    tick();
    idle_inputs();
    ll_valid = 1'b1; ll_rd = 5'd0; ll_data = 32'h77;
    tick();
    idle_cycles(3);
    expect_wr(5'd9, 32'h0000_9999);
    ll_issue_valid = 1'b1; ll_issue_rd = 5'd9;
    tick();
    idle_inputs();
    ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h0000_9999;
    tick();
    idle_inputs();
    ll_issue_valid = 1'b1; ll_issue_rd = 5'd9;
    tick();
    idle_inputs();
    @(negedge clk);
    check("t5_busy_set_wins", rd_busy, 32'h0000_0200);
    tick();
    idle_cycles(2);

    // 6: reset with three buffered results and busy=0x680
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      expect_wr(5'd20, 32'h300 + 32'(c));
      pipe_valid = 1'b1; pipe_we = 1'b1; pipe_rd = 5'd20; pipe_data = 32'h300 + 32'(c);
      ll_valid = 1'b1; ll_rd = (c == 0) ? 5'd7 : ((c == 1) ? 5'd9 : 5'd10);
      ll_data = 32'hCC00_0000 + 32'(c);
      ll_issue_valid = 1'b1; ll_issue_rd = ll_rd;
      tick();
    end
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    check("t6_busy_before_rst", rd_busy, 32'h0000_0680);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_busy_after_rst", rd_busy, 32'd0);
    check("t6_ll_ready_after_rst", 32'(ll_ready), 32'd1);
    check("t6_wr_en_after_rst", 32'(rf_wr_en), 32'd0);
    check("t6_pipe_ready_after_rst", 32'(pipe_ready), 32'd1);
    tick();
    idle_cycles(10);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Producer side of the 1-write/2-read register file port: merges in-order pipeline results with out-of-order long-latency results (divider, load miss) into the single rf write port.
- Buffers long-latency results in a small FIFO and prevents starvation with an age counter.
- Keeps a busy scoreboard of registers that still have an outstanding long-latency write.
- Sits between the MEM/WB pipeline register and the register file.

Parameters:
- LL_DEPTH, 4, long-latency result FIFO depth; power of two, at least 2.
- STARVE_MAX, 8, cycles the FIFO head may wait before it preempts the pipeline.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pipe_valid  in  1  pipeline result present.
- pipe_we  in  1  result writes a register; if 0 the result is consumed with no write.
- pipe_rd  in  5  destination register.
- pipe_data  in  32  result value.
- pipe_ready  out  1  pipeline result accepted this cycle; upstream stalls when 0.
- ll_valid  in  1  long-latency result present.
- ll_rd  in  5  destination register.
- ll_data  in  32  result value.
- ll_ready  out  1  FIFO not full.
- ll_issue_valid  in  1  long-latency op issued this cycle.
- ll_issue_rd  in  5  its destination register.
- rd_busy  out  32  bit n set means register n has a pending long-latency write.
- rf_wr_en  out  1  register file write enable.
- rf_wr_addr  out  5  register file write address.
- rf_wr_data  out  32  register file write data.

Behaviour:
- Reset state: rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, rd_busy=0, FIFO empty, starve counter=0.
- ll_ready=1 and pipe_ready=1 in the first cycle after reset.
- LL push: when ll_valid && ll_ready, push {rd,data} into the FIFO.
  - ll_ready = !full. It is combinational from FIFO state only.
- Grant evaluation, once per cycle:
  - GRANT_LL when the FIFO is non-empty and either (a) pipe_valid=0, or (b) starve_cnt reached STARVE_MAX-1, or (c) the FIFO is full.
  - GRANT_PIPE otherwise, when pipe_valid=1.
- pipe_ready:
  - Equals !(FIFO non-empty and (starve_cnt==STARVE_MAX-1 or full)).
  - It is 1 whenever the FIFO is empty.
  - It does not depend on pipe_valid.
- A pipe result with pipe_we=0 still consumes its grant, but no write is issued.
- Output stage: registered, 1-cycle latency. In the cycle after a grant:
  - rf_wr_en = granted_we && (rd != 0).
  - rf_wr_addr and rf_wr_data take the winner's values.
- When there is no grant, rf_wr_en=0. rf_wr_addr and rf_wr_data hold their last values.
- Writes to x0 are accepted and dropped: rf_wr_en stays 0. For LL results the pop still occurs.
- FIFO pop occurs in the GRANT_LL cycle.
- Push and pop in the same cycle is allowed, including when full: ll_ready is computed before the pop, so a full FIFO still shows ll_ready=0.
- starve_cnt:
  - Increments each cycle the FIFO is non-empty and the head is not popped.
  - Resets to 0 on any pop or when the FIFO is empty.
  - Saturates at STARVE_MAX-1.
- Scoreboard:
  - rd_busy[ll_issue_rd] is set on ll_issue_valid (x0 is ignored).
  - rd_busy[rd] is cleared when that LL entry is popped.
  - If set and clear hit the same register in the same cycle, set wins.
  - Pipeline writes never touch rd_busy.
- Ordering:
  - Pipeline results are written in arrival order.
  - LL results are written in FIFO order.
  - No ordering is enforced between the two streams; issue logic must stall on rd_busy to avoid WAW hazards.
- Reset mid-operation flushes the FIFO and clears rd_busy, dropping pending results silently. The next-cycle rf_wr_en=0.

Decomposition:
- Shared package wb_pkg holds XLEN=32, REG_ADDR_W=5, NUM_REGS=32, and the enum grant_t {GRANT_NONE, GRANT_PIPE, GRANT_LL}.
- One sub-module, wb_result_fifo: synchronous FIFO with parameterised depth, push/pop, full/empty, a (REG_ADDR_W+XLEN)-bit entry, and a wrap-around pointer plus one extra bit.
- Arbiter, starve counter, scoreboard and output register live in the top-level module.

Test Plan:
1. Pipe only: pipe_valid=1, pipe_we=1, rd=5, data=0xDEADBEEF, FIFO empty -> next cycle rf_wr_en=1, addr=5, data=0xDEADBEEF, pipe_ready stays 1.
2. LL idle slot: ll_valid=1, rd=7, data=0x12345678 with pipe_valid=0 -> pushed, popped the following cycle, rf_wr_en=1 with addr=7 one cycle after that. rd_busy[7], set earlier by issue, clears the same cycle as the pop.
3. Starvation: STARVE_MAX=8, one LL entry, pipe_valid held 1 -> pipe wins 7 cycles, then pipe_ready=0 for one cycle, LL written, pipe resumes.
4. FIFO full: 4 LL pushes while pipe is continuous -> ll_ready=0 after the 4th push, pipe_ready=0, LL drains; a push with a simultaneous pop while full is rejected.
5. x0 and scoreboard collision: pipe result to rd=0 gives rf_wr_en=0. ll_issue_rd=9 in the same cycle as the pop of rd=9 leaves rd_busy[9]=1.
6. Reset with 3 FIFO entries and rd_busy=0x0000_0680 -> rst=1 for one cycle, then rd_busy=0, ll_ready=1, rf_wr_en=0, and no stale writes appear afterwards.
